// File: rtl/gf180mcu_fd_sc_mcu9t5v0__icg_en_ctl.sv
// Enable controller for an integrated clock gate: wakes the gated domain on
// demand, flags it ready after a fixed settle time, and shuts it down after an idle hold-off.
module gf180mcu_fd_sc_mcu9t5v0__icg_en_ctl #(
    parameter int unsigned WAKE_CYC = 2,
    parameter int unsigned DLY_W    = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             REQ,
    input  logic             BUSY,
    input  logic             FORCE_ON,
    input  logic [DLY_W-1:0] IDLE_DLY,
    output logic             E,
    output logic             RDY,
    output logic [1:0]       STATE
);

    typedef enum logic [1:0] {
        S_OFF   = 2'd0,
        S_WAKE  = 2'd1,
        S_ON    = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    localparam logic [3:0] WAKE_LOAD = 4'(WAKE_CYC - 1);

    state_t           state, state_nxt;
    logic [3:0]       wake_cnt, wake_cnt_nxt;
    logic [DLY_W-1:0] idle_cnt, idle_cnt_nxt;
    logic             act;

    always_comb begin
        act          = REQ | BUSY | FORCE_ON;
        state_nxt    = state;
        wake_cnt_nxt = wake_cnt;
        idle_cnt_nxt = idle_cnt;
        unique case (state)
            S_OFF: begin
                if (act) begin
                    state_nxt    = S_WAKE;
                    wake_cnt_nxt = WAKE_LOAD;
                end
            end
            // Wake always runs to completion so RDY timing is fixed relative to E.
            S_WAKE: begin
                if (wake_cnt == '0) state_nxt = S_ON;
                else                wake_cnt_nxt = wake_cnt - 4'd1;
            end
            S_ON: begin
                if (!act) begin
                    state_nxt    = S_DRAIN;
                    idle_cnt_nxt = IDLE_DLY;
                end
            end
            // Activity beats an expiring counter; at zero we leave rather than wrap.
            S_DRAIN: begin
                if (act)                 state_nxt = S_ON;
                else if (idle_cnt == '0) state_nxt = S_OFF;
                else                     idle_cnt_nxt = idle_cnt - 1'b1;
            end
            default: state_nxt = S_OFF;
        endcase
    end

    // E and RDY are registered from the next state so they come straight off flops.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= S_OFF;
            wake_cnt <= '0;
            idle_cnt <= '0;
            E        <= 1'b0;
            RDY      <= 1'b0;
        end else begin
            state    <= state_nxt;
            wake_cnt <= wake_cnt_nxt;
            idle_cnt <= idle_cnt_nxt;
            E        <= (state_nxt != S_OFF);
            RDY      <= (state_nxt == S_ON) || (state_nxt == S_DRAIN);
        end
    end

    assign STATE = state;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__icg_en_ctl.sv
// Directed-vector bench for the ICG enable controller; expected outputs go
// through a scoreboard queue checked by an independent monitor on the falling edge.
module tb_gf180mcu_fd_sc_mcu9t5v0__icg_en_ctl;

    logic       clk = 1'b0;
    logic       rst, req, busy, force_on;
    logic [3:0] idle_dly;
    logic       e, rdy;
    logic [1:0] state;

    gf180mcu_fd_sc_mcu9t5v0__icg_en_ctl #(
        .WAKE_CYC(2),
        .DLY_W   (4)
    ) dut (
        .CLK     (clk),
        .RST     (rst),
        .REQ     (req),
        .BUSY    (busy),
        .FORCE_ON(force_on),
        .IDLE_DLY(idle_dly),
        .E       (e),
        .RDY     (rdy),
        .STATE   (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst, req, busy, fo;
        logic [3:0] dly;
        logic       e, rdy;
        logic [1:0] st;
    } vec_t;

    typedef struct {
        logic       e, rdy;
        logic [1:0] st;
        int         idx;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   chk_cnt  = 0;
    int   pass_cnt = 0;

    function automatic void add(input logic r, input logic q, input logic b, input logic f,
                                input logic [3:0] d, input logic xe, input logic xr,
                                input logic [1:0] xs);
        vec_t v;
        v.rst = r; v.req = q; v.busy = b; v.fo = f; v.dly = d;
        v.e = xe; v.rdy = xr; v.st = xs;
        vecs.push_back(v);
    endfunction

    // Monitor: every falling edge with an expectation pending is compared.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t x;
            x = sb.pop_front();
            chk_cnt++;
            if ({e, rdy, state} !== {x.e, x.rdy, x.st})
                $display("FAIL vec%0d: got E=%b RDY=%b STATE=%0d, want E=%b RDY=%b STATE=%0d",
                         x.idx, e, rdy, state, x.e, x.rdy, x.st);
            else
                pass_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; req = 1'b0; busy = 1'b0; force_on = 1'b0; idle_dly = 4'd0;

        // reset, and reset beating REQ
        add(1,0,0,0,0, 0,0,0);
        add(1,1,0,1,0, 0,0,0);
        // wake with WAKE_CYC=2: RDY two edges after E
        add(0,1,0,0,0, 1,0,1);
        add(0,1,0,0,0, 1,0,1);
        add(0,1,0,0,0, 1,1,2);
        add(0,1,0,0,0, 1,1,2);
        // IDLE_DLY=3: E falls on the 4th edge after the first idle edge
        add(0,0,0,0,3, 1,1,3);
        add(0,0,0,0,3, 1,1,3);
        add(0,0,0,0,3, 1,1,3);
        add(0,0,0,0,3, 1,1,3);
        add(0,0,0,0,3, 0,0,0);
        add(0,0,0,0,3, 0,0,0);
        // BUSY pulse at counter=1 restarts the count; IDLE_DLY changes in DRAIN ignored
        add(0,1,0,0,3, 1,0,1);
        add(0,1,0,0,3, 1,0,1);
        add(0,1,0,0,3, 1,1,2);
        add(0,0,0,0,3, 1,1,3);
        add(0,0,0,0,0, 1,1,3);
        add(0,0,0,0,0, 1,1,3);
        add(0,0,1,0,0, 1,1,2);
        add(0,0,0,0,3, 1,1,3);
        add(0,0,0,0,0, 1,1,3);
        add(0,0,0,0,0, 1,1,3);
        add(0,0,0,0,0, 1,1,3);
        add(0,0,0,0,0, 0,0,0);
        // act at counter=0 wins, then IDLE_DLY=0 shuts down on the second idle edge
        add(0,1,0,0,1, 1,0,1);
        add(0,1,0,0,1, 1,0,1);
        add(0,1,0,0,1, 1,1,2);
        add(0,0,0,0,1, 1,1,3);
        add(0,0,0,0,1, 1,1,3);
        add(0,1,0,0,1, 1,1,2);
        add(0,0,0,0,0, 1,1,3);
        add(0,0,0,0,0, 0,0,0);
        // IDLE_DLY=15: E low after k+16, counter never wraps
        add(0,1,0,0,15, 1,0,1);
        add(0,1,0,0,15, 1,0,1);
        add(0,1,0,0,15, 1,1,2);
        add(0,0,0,0,15, 1,1,3);
        for (int i = 0; i < 15; i++) add(0,0,0,0,15, 1,1,3);
        add(0,0,0,0,15, 0,0,0);
        // single-cycle REQ: wake still completes to ON
        add(0,1,0,0,0, 1,0,1);
        add(0,0,0,0,0, 1,0,1);
        add(0,0,0,0,0, 1,1,2);
        add(0,0,0,0,0, 1,1,3);
        add(0,0,0,0,0, 0,0,0);
        // reset mid-WAKE with REQ held: WAKE on the first post-reset edge
        add(0,1,0,0,3, 1,0,1);
        add(1,1,0,0,3, 0,0,0);
        add(0,1,0,0,3, 1,0,1);
        add(0,1,0,0,3, 1,0,1);
        add(0,1,0,0,3, 1,1,2);
        // reset mid-DRAIN
        add(0,0,0,0,3, 1,1,3);
        add(0,0,0,0,3, 1,1,3);
        add(1,0,0,0,3, 0,0,0);
        add(0,0,0,0,3, 0,0,0);
        // FORCE_ON alone: full wake, held on, rescues DRAIN, then shutdown at k+IDLE_DLY+1
        add(0,0,0,1,2, 1,0,1);
        add(0,0,0,1,2, 1,0,1);
        add(0,0,0,1,2, 1,1,2);
        for (int i = 0; i < 5; i++) add(0,0,0,1,2, 1,1,2);
        add(0,0,0,0,2, 1,1,3);
        add(0,0,0,1,2, 1,1,2);
        add(0,0,0,0,2, 1,1,3);
        add(0,0,0,0,2, 1,1,3);
        add(0,0,0,0,2, 1,1,3);
        add(0,0,0,0,2, 0,0,0);

        foreach (vecs[i]) begin
            exp_t x;
            rst = vecs[i].rst; req = vecs[i].req; busy = vecs[i].busy;
            force_on = vecs[i].fo; idle_dly = vecs[i].dly;
            @(posedge clk);
            x.e = vecs[i].e; x.rdy = vecs[i].rdy; x.st = vecs[i].st; x.idx = i;
            sb.push_back(x);
            #1;
        end

        repeat (3) @(negedge clk);
        #1;
        chk_cnt++;
        if (sb.size() != 0)
            $display("FAIL drain: got %0d pending expectations, want 0", sb.size());
        else
            pass_cnt++;

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
